// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_ctrl_pkg: register map, status bit positions and serializer state encoding
package uart_tx_ctrl_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF = 2;
    localparam int STAT_ACTIVE = 3;
    localparam int STAT_CNT_LSB = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// uart_tx_ctrl_sync_fifo: circular byte FIFO; full/empty judged on pre-edge count
module uart_tx_ctrl_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;
    assign o_full = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop = i_pop & ~o_empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: wishbone-attached UART transmitter, FIFO-buffered 8N1 serializer
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic        tx_o,
    output logic        tx_busy_o
);
    tx_state_t      r_state;
    tx_state_t      w_nxt_state;
    logic [15:0]    r_baud;
    logic [15:0]    w_nxt_baud;
    logic [2:0]     r_bit;
    logic [2:0]     w_nxt_bit;
    logic [7:0]     r_shift;
    logic [7:0]     w_nxt_shift;
    logic           r_tx;
    logic           w_nxt_tx;
    logic           r_busy;
    logic           r_ack;
    logic [31:0]    r_rdata;
    logic           r_ovf;
    logic           w_req;
    logic [1:0]     w_sel;
    logic           w_push;
    logic           w_rd_status;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [FIFO_AW:0] w_count;
    logic [7:0]     w_fifo_data;
    logic [31:0]    w_status;
    logic           w_bit_end;
    logic           w_unused;
    assign w_unused = ^{wb_addr_i[1:0], wb_data_i[31:8]};
    assign wb_ack_o = r_ack;
    assign wb_data_o = r_rdata;
    assign tx_o = r_tx;
    assign tx_busy_o = r_busy;
    assign w_req = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_sel = wb_addr_i[3:2];
    assign w_push = w_req & wb_we_i & (w_sel == REG_DATA);
    assign w_rd_status = w_req & ~wb_we_i & (w_sel == REG_STATUS);
    assign w_bit_end = r_baud == 16'(CLKS_PER_BIT - 1);

    uart_tx_ctrl_sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (wb_data_i[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status = '0;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_FULL] = w_full;
        w_status[STAT_OVF] = r_ovf;
        w_status[STAT_ACTIVE] = r_state != ST_IDLE;
        w_status[STAT_CNT_LSB +: 8] = 8'(w_count);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req & ~wb_we_i) r_rdata <= w_rd_status ? w_status : '0;
            // a dropped byte outranks nothing else: a read and a write never share an edge
            if (w_push & w_full) r_ovf <= 1'b1;
            else if (w_rd_status) r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_baud = r_baud + 16'd1;
        w_nxt_bit = r_bit;
        w_nxt_shift = r_shift;
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_nxt_baud = '0;
            ST_START: if (w_bit_end) begin
                w_nxt_baud = '0;
                w_nxt_state = ST_DATA;
            end
            ST_DATA: if (w_bit_end) begin
                w_nxt_baud = '0;
                w_nxt_shift = r_shift >> 1;
                w_nxt_bit = r_bit + 3'd1;
                if (r_bit == 3'd7) w_nxt_state = ST_STOP;
            end
            ST_STOP: if (w_bit_end) begin
                w_nxt_baud = '0;
                w_nxt_state = ST_IDLE;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
        // chaining from the stop bit straight into the next start avoids an idle gap
        if ((r_state == ST_IDLE || (r_state == ST_STOP && w_bit_end)) && !w_empty) begin
            w_pop = 1'b1;
            w_nxt_shift = w_fifo_data;
            w_nxt_bit = '0;
            w_nxt_baud = '0;
            w_nxt_state = ST_START;
        end
        w_nxt_tx = (w_nxt_state == ST_START) ? 1'b0 :
                   (w_nxt_state == ST_DATA) ? w_nxt_shift[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_baud  <= w_nxt_baud;
            r_bit   <= w_nxt_bit;
            r_shift <= w_nxt_shift;
            r_tx    <= w_nxt_tx;
            r_busy  <= (r_state != ST_IDLE) | ~w_empty;
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed/random bus stimulus with a line-level frame decoder as reference
module tb_uart_tx_ctrl;
    localparam int C = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic [31:0] wb_data_o;
    logic        wb_ack_o;
    logic        tx_o;
    logic        tx_busy_o;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          starts[$];
    logic        mon_abort = 1'b0;
    logic [7:0]  mon_b;
    logic        mon_start_ok;
    logic [31:0] rd;
    logic [31:0] held;
    logic [39:0] cap;
    logic [39:0] cap_exp;
    logic [9:0]  frame;
    logic [3:0]  ack_pat;
    logic [7:0]  first_b;
    logic [7:0]  extra [17];
    int          s0;

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .wb_we_i   (wb_we_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_data_o (wb_data_o),
        .wb_ack_o  (wb_ack_o),
        .tx_o      (tx_o),
        .tx_busy_o (tx_busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wd, output logic [31:0] rdv);
        @(negedge clk);
        wb_addr_i = addr; wb_data_i = wd; wb_we_i = we; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("ack_rise", wb_ack_o, 1);
        rdv = wb_data_o;
        @(negedge clk);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", wb_ack_o, 0);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(1'b1, addr, wd, dummy);
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        check("rx_wait", rx_q.size() >= n, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (tx_busy_o !== 1'b0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("idle_wait", tx_busy_o, 0);
    endtask

    task automatic drain(input string tag);
        check("rx_count", rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0) check(tag, rx_q.pop_front(), exp_q.pop_front());
        rx_q.delete();
        exp_q.delete();
    endtask

    // line decoder: samples each bit at its midpoint, forgets frames cut by reset
    initial forever begin
        @(negedge tx_o);
        if (rst) begin
            starts.push_back(cyc_cnt);
            mon_abort = 1'b0;
            repeat (C / 2) @(posedge clk);
            #1 mon_start_ok = ~tx_o;
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(posedge clk);
                #1 mon_b[i] = tx_o;
            end
            repeat (C) @(posedge clk);
            #1;
            if (!mon_abort) begin
                check("start_bit", mon_start_ok, 1);
                check("stop_bit", tx_o, 1);
                rx_q.push_back(mon_b);
            end
        end
    end
    initial forever begin
        @(negedge rst);
        mon_abort = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", wb_ack_o, 0);
        check("rst_data", wb_data_o, 0);
        check("rst_tx", tx_o, 1);
        check("rst_busy", tx_busy_o, 0);
        @(negedge clk) rst = 1'b1;

        // idle after release
        repeat (100) @(posedge clk);
        #1;
        check("idle_tx", tx_o, 1);
        check("idle_busy", tx_busy_o, 0);
        bus(1'b0, 4'h4, '0, rd);
        check("idle_status", rd, 32'h1);

        // single frame 0xA5, level-by-level
        wr(4'h0, 32'h0000_00A5);
        exp_q.push_back(8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) cap_exp[k] = frame[k / C];
        check("busy_during", tx_busy_o, 1);
        cap[0] = tx_o;
        for (int k = 1; k < 40; k++) begin
            @(posedge clk); #1;
            cap[k] = tx_o;
        end
        check("a5_waveform", cap, cap_exp);
        @(posedge clk); #1;
        check("a5_idle_after", tx_o, 1);
        check("busy_stop_end", tx_busy_o, 1);
        @(posedge clk); #1;
        check("busy_falls", tx_busy_o, 0);
        wait_rx(1);
        drain("a5_byte");

        // back-to-back bytes, no inter-frame gap
        s0 = starts.size();
        for (int i = 0; i < 3; i++) begin
            wr(4'h0, 32'h41 + i);
            exp_q.push_back(8'h41 + 8'(i));
        end
        wait_rx(3);
        check("gap_1", starts[s0 + 1] - starts[s0], 10 * C);
        check("gap_2", starts[s0 + 2] - starts[s0 + 1], 10 * C);
        drain("b2b_byte");
        wait_idle();

        // overflow while the first frame holds the serializer
        first_b = 8'($urandom);
        for (int i = 0; i < 17; i++) extra[i] = 8'($urandom);
        wr(4'h0, {24'h0, first_b});
        exp_q.push_back(first_b);
        for (int i = 0; i < 17; i++) begin
            wr(4'h0, {24'h0, extra[i]});
            if (i < 16) exp_q.push_back(extra[i]);
        end
        bus(1'b0, 4'h4, '0, rd);
        check("ovf_status", rd, 32'h0000_100E);
        bus(1'b0, 4'h4, '0, rd);
        check("ovf_cleared", rd, 32'h0000_100A);
        wait_rx(17);
        repeat (100) @(posedge clk);
        drain("ovf_byte");
        wait_idle();

        // reset in the middle of data bit 3 of 0x55
        wr(4'h0, 32'h55);
        repeat (17) @(posedge clk);
        #1;
        check("bit3_low", tx_o, 0);
        rst = 1'b0;
        #1;
        check("async_tx_high", tx_o, 1);
        check("async_busy", tx_busy_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        s0 = starts.size();
        repeat (80) @(posedge clk);
        #1;
        check("post_rst_starts", starts.size(), s0);
        check("post_rst_rx", rx_q.size(), 0);
        bus(1'b0, 4'h4, '0, rd);
        check("post_rst_status", rd, 32'h1);

        // unmapped offsets, read-only status, data-out hold
        held = rd;
        wr(4'h8, 32'h77);
        check("rdata_hold", wb_data_o, held);
        bus(1'b0, 4'hC, '0, rd);
        check("rd_0xC", rd, 0);
        bus(1'b0, 4'h0, '0, rd);
        check("rd_data", rd, 0);
        wr(4'h4, 32'hFFFF_FFFF);
        bus(1'b0, 4'h4, '0, rd);
        check("unchanged_status", rd, 32'h1);
        @(negedge clk);
        wb_addr_i = 4'h4; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            ack_pat[k] = wb_ack_o;
        end
        @(negedge clk);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        check("ack_every_other", ack_pat, 4'b0101);

        // random burst
        for (int i = 0; i < 8; i++) begin
            first_b = 8'($urandom);
            wr(4'h0, {24'h0, first_b});
            exp_q.push_back(first_b);
        end
        wait_rx(8);
        drain("rand_byte");
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Bus-side UART transmit controller that sits directly downstream of the SOPC wishbone master (through bus_top's address decode) and drives the serial com_TxD pin.
- CPU stores bytes to a data register; they are buffered in a byte FIFO and serialized 8N1 at a fixed baud.
- A status register lets polling software check buffer state and overflow.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- FIFO_AW, 4, log2(FIFO_DEPTH); must match FIFO_DEPTH.

Ports:
- clk  in  1  single clock for bus side and serializer.
- rst  in  1  asynchronous, active-low reset.
- wb_addr_i  in  4  byte offset within block; only [3:2] decoded.
- wb_data_i  in  32  write data; only [7:0] used.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_stb_i  in  1  strobe; block selected by bus_top decode.
- wb_cyc_i  in  1  bus cycle valid.
- wb_data_o  out  32  read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- tx_o  out  1  serial output; idle high.
- tx_busy_o  out  1  1 while a frame is on the line or FIFO is non-empty.

Behaviour:
Reset (rst=0, asynchronous):
- wb_ack_o=0, wb_data_o=0, tx_o=1, tx_busy_o=0.
- FIFO emptied; overflow flag cleared; FSM forced to IDLE.
- Reset asserted mid-frame truncates the frame; tx_o goes high immediately.

Bus handshake:
- Request = wb_stb_i & wb_cyc_i & ~wb_ack_o.
- wb_ack_o rises the cycle after a request and stays high exactly 1 cycle.
- Back-to-back requests are acked every other cycle.
- Side effects and wb_data_o update occur on the same edge that sets ack.
- wb_data_o holds its value until the next read ack.

Register map (wb_addr_i[3:2]):
- 0 DATA:
  - Write pushes wb_data_i[7:0] when the FIFO is not full.
  - When full, the byte is dropped, the overflow flag is set, and the write is still acked.
  - Read returns 0.
- 1 STATUS (read only):
  - bit0 fifo_empty, bit1 fifo_full, bit2 overflow (sticky), bit3 fsm_active, bits[15:8] fifo_count, others 0.
  - A read returns the current overflow value, then clears it on the ack edge.
  - Writes have no effect.
- 2, 3: reads return 0; writes are ignored and acked.

FIFO:
- Circular buffer; wr_ptr and rd_ptr are FIFO_AW bits wide and wrap naturally.
- count is FIFO_AW+1 bits; full when count==FIFO_DEPTH; empty when count==0.
- Full/empty are evaluated on pre-edge state.
- Push while full is rejected even if a pop occurs on the same edge.
- Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.

TX FSM (states IDLE, START, DATA, STOP):
- IDLE, tx_o=1:
  - If the FIFO is non-empty, pop one byte into the shift register, clear bit_cnt and baud_cnt, go to START.
  - First start-bit cycle is 1 clk after the pop edge.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_o = shift[0], LSB first.
  - Each bit lasts CLKS_PER_BIT cycles; shift right after each bit.
  - After bit_cnt==7 completes, go to STOP.
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - If the FIFO is non-empty at the STOP end, pop directly and enter START (no idle gap).
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- baud_cnt counts 0..CLKS_PER_BIT-1 and is 16 bits wide.
- tx_busy_o = (state!=IDLE) | ~fifo_empty, registered.

Decomposition:
- Shared package/defines:
  - register offsets (DATA=0, STATUS=1);
  - STATUS bit indices;
  - FSM state encodings (2 bits: IDLE=0, START=1, DATA=2, STOP=3);
  - default CLKS_PER_BIT.
- Sub-module sync_fifo: parameterized byte FIFO with push/pop/full/empty/count.
- Bus decode and serializer FSM stay in uart_tx_ctrl.

Test Plan:
1. Reset release, then idle 100 cycles -> tx_o=1, tx_busy_o=0, STATUS read returns 0x00000001 (empty), ack high exactly 1 cycle.
2. CLKS_PER_BIT=4; write DATA=0x000000A5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; total 40 cycles; tx_busy_o falls after stop.
3. CLKS_PER_BIT=4, FIFO_DEPTH=16; write 0x41,0x42,0x43 back-to-back -> three frames, no idle gap between stop and next start, decoded bytes 0x41,0x42,0x43 in order.
4. Hold serializer off (first frame in progress); write 17 more bytes -> STATUS shows count=16, full=1, overflow=1; second STATUS read shows overflow=0; the 17th extra byte is never transmitted.
5. Assert rst low mid-DATA bit 3 of 0x55 -> tx_o=1 asynchronously; after release the FIFO is empty and no residual frame is sent.
6. Write to offset 0x8 and read offset 0xC -> both acked, read data 0, FIFO count unchanged.
